// File: rtl/demux_5channel_buf.sv
// One-to-five demultiplexer with a single-entry holding register per channel.
// Illegal selects (5..7) are swallowed and tallied in a sticky error/drop counter.
module demux_5channel_buf #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [2:0]           select,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out1,
    output logic [DATAWIDTH-1:0] out2,
    output logic [DATAWIDTH-1:0] out3,
    output logic [DATAWIDTH-1:0] out4,
    output logic [DATAWIDTH-1:0] out5,
    output logic [4:0]           out_valid,
    input  logic [4:0]           out_ready,
    input  logic                 err_clr,
    output logic                 err_sel,
    output logic [3:0]           drop_cnt
);

    localparam int NUM_CH = 5;

    logic [DATAWIDTH-1:0] data_q [NUM_CH];
    logic [NUM_CH-1:0]    valid_q;
    logic [NUM_CH-1:0]    sel_onehot;
    logic [NUM_CH-1:0]    load;
    logic [NUM_CH-1:0]    drain;
    logic                 sel_legal;
    logic                 accept;
    logic                 drop;
    logic                 err_q;
    logic [3:0]           cnt_q;

    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_onehot[k] = (select == 3'(k));
        end
    end

    assign sel_legal = (select < 3'(NUM_CH));

    // A full channel frees up in the same cycle its consumer takes the word.
    assign in_ready = sel_legal ? (|(sel_onehot & (~valid_q | out_ready))) : 1'b1;

    assign accept = in_valid & in_ready;
    assign load   = sel_onehot & {NUM_CH{accept}};
    assign drain  = valid_q & out_ready;
    assign drop   = accept & ~sel_legal;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q[g]  <= '0;
                valid_q[g] <= 1'b0;
            end else if (load[g]) begin
                data_q[g]  <= in_data;
                valid_q[g] <= 1'b1;
            end else if (drain[g]) begin
                valid_q[g] <= 1'b0;
            end
        end
    end

    // A drop coinciding with a clear wins, leaving a count of exactly one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            cnt_q <= 4'd0;
        end else if (drop) begin
            err_q <= 1'b1;
            if (err_clr) begin
                cnt_q <= 4'd1;
            end else if (cnt_q != 4'hF) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end else if (err_clr) begin
            err_q <= 1'b0;
            cnt_q <= 4'd0;
        end
    end

    assign out1      = data_q[0];
    assign out2      = data_q[1];
    assign out3      = data_q[2];
    assign out4      = data_q[3];
    assign out5      = data_q[4];
    assign out_valid = valid_q;
    assign err_sel   = err_q;
    assign drop_cnt  = cnt_q;

endmodule
